// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 8-way round-robin arbiter with registered one-hot and binary grant.
// Defining ARB_TIMEOUT_EN adds a forced release after HOLD_MAX grant cycles.
module rr_decode_arbiter #(
    parameter logic [2:0] RESET_PTR = 3'd0,
    parameter int         HOLD_MAX  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt, idx_nxt, scan_idx, win_idx;
    logic [7:0] gnt_nxt, cand;
    logic       win_found, vld_nxt, force_rel;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt, hold_cnt_nxt, excl, excl_nxt;

    assign force_rel = (state == GRANT) && req[gnt_idx] && (hold_cnt == 8'(HOLD_MAX - 1));
    assign cand      = req & ~excl;

    // A force-released holder stays excluded until its request is observed low.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        excl_nxt     = excl & req;
        if (state == IDLE)
            hold_cnt_nxt = '0;
        else
            hold_cnt_nxt = hold_cnt + 8'd1;
        if (force_rel)
            excl_nxt = excl_nxt | (8'd1 << gnt_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            excl     <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            excl     <= excl_nxt;
            timeout  <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign cand      = req;
    assign timeout   = 1'b0;
`endif

    // Circular scan starting at ptr; first candidate found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        scan_idx  = ptr;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr + i[2:0];
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        gnt_nxt   = gnt;
        vld_nxt   = gnt_vld;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = GRANT;
                    idx_nxt   = win_idx;
                    gnt_nxt   = 8'd1 << win_idx;
                    vld_nxt   = 1'b1;
                end
            end
            GRANT: begin
                // Release always passes through IDLE, which gives the turnaround cycle.
                if (!req[gnt_idx] || force_rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    vld_nxt   = 1'b0;
                    ptr_nxt   = gnt_idx + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= RESET_PTR;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= vld_nxt;
        end
    end
endmodule
